// File: rtl/rfsoc_config_pkg.sv
// Shared RFSoC datapath constants and types.
// Used by the PL-to-PS AXI-Stream width converter.
package rfsoc_config;

    localparam int pl_width = 256;
    localparam int ps_width_default = 32;
    localparam int words_per_beat = pl_width / ps_width_default;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    function automatic int beat_words(input int ps_width);
        return pl_width / ps_width;
    endfunction

endpackage

// File: rtl/axis_pl_to_ps.sv
// 256-bit PL AXI-Stream beats split into narrower PS words, MSB word first.
// A one-entry skid buffer lets the next beat land while the current one drains.
module axis_pl_to_ps
    import rfsoc_config::*;
#(
    parameter int ps_axis_width = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [pl_width-1:0]      s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [ps_axis_width-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast
);

    localparam int wpb = beat_words(ps_axis_width);
    localparam int cw = (wpb > 1) ? $clog2(wpb) : 1;
    localparam logic [cw-1:0] last_cnt = cw'(wpb - 1);

    if (pl_width % ps_axis_width != 0) begin : g_bad_width
        $error("ps_axis_width must divide 256");
    end

    state_t              state, state_n;
    logic [pl_width-1:0] sreg, sreg_n;
    logic [pl_width-1:0] hbuf, hbuf_n;
    logic [cw-1:0]       cnt, cnt_n;
    logic                hvalid, hvalid_n;
    logic                accept;
    logic                last_hs;

    assign s_axis_tready = ~hvalid;
    assign accept        = s_axis_tvalid & ~hvalid;
    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tlast  = (state == SEND) && (cnt == last_cnt);
    assign m_axis_tdata  = sreg[pl_width-1 -: ps_axis_width];
    assign last_hs       = m_axis_tlast & m_axis_tready;

    always_comb begin
        state_n  = state;
        sreg_n   = sreg;
        cnt_n    = cnt;
        hbuf_n   = hbuf;
        hvalid_n = hvalid;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    sreg_n  = s_axis_tdata;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (cnt != last_cnt) begin
                        sreg_n = sreg << ps_axis_width;
                        cnt_n  = cnt + cw'(1);
                    end else if (hvalid) begin
                        sreg_n   = hbuf;
                        hvalid_n = 1'b0;
                        cnt_n    = '0;
                    end else if (accept) begin
                        sreg_n = s_axis_tdata;
                        cnt_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                // A beat arriving on the final handshake bypasses the skid slot
                if (accept && !last_hs) begin
                    hbuf_n   = s_axis_tdata;
                    hvalid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            hbuf   <= '0;
            cnt    <= '0;
            hvalid <= 1'b0;
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            hbuf   <= hbuf_n;
            cnt    <= cnt_n;
            hvalid <= hvalid_n;
        end
    end

endmodule

// File: doc/axis_pl_to_ps.md
AXIS_PL_TO_PS -- requirements
Module: axis_pl_to_ps

Interface
REQ-001 Parameter: ps_axis_width, default 32, width in bits of each PS-side AXIS word; it SHALL divide 256 exactly.
REQ-002 Derived constant: words_per_beat = 256 / ps_axis_width (8 at default).
REQ-003 clk  input  1  block clock; PL and PS sides are synchronous to it.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  input  256  PL-side input data beat.
REQ-006 s_axis_tvalid  input  1  PL beat valid.
REQ-007 s_axis_tready  output  1  block can accept a PL beat.
REQ-008 m_axis_tdata  output  ps_axis_width  PS-side output word.
REQ-009 m_axis_tvalid  output  1  PS word valid.
REQ-010 m_axis_tready  input  1  PS sink accepts word.
REQ-011 m_axis_tlast  output  1  marks the final PS word of each 256-bit beat.

Function
REQ-012 Storage SHALL be a 256-bit shift register (sreg), a word counter (cnt, 0..words_per_beat-1), a 256-bit holding register (hbuf) with flag hvalid, and a 2-state FSM {IDLE, SEND}.
REQ-013 s_axis_tready SHALL equal !hvalid, driven from a register with no combinational path from any input.
REQ-014 A PL beat is accepted only on a cycle with s_axis_tvalid && s_axis_tready.
REQ-015 IDLE with an accepted beat: load sreg from s_axis_tdata, cnt<=0, go to SEND; m_axis_tvalid is high on the next cycle (1-cycle latency).
REQ-016 SEND with an accepted beat: store it in hbuf and set hvalid.
REQ-017 m_axis_tdata SHALL be sreg[255 : 256-ps_axis_width], so the most-significant word of each beat is sent first and bits [ps_axis_width-1:0] are sent last.
REQ-018 m_axis_tvalid SHALL be 1 exactly in SEND; once asserted, m_axis_tdata and m_axis_tlast SHALL stay stable until the handshake completes.
REQ-019 On a SEND handshake with cnt < words_per_beat-1: shift sreg left by ps_axis_width (zero fill) and increment cnt.
REQ-020 m_axis_tlast SHALL be 1 exactly when SEND and cnt == words_per_beat-1.
REQ-021 On the last-word handshake: if hvalid, load sreg from hbuf, clear hvalid, cnt<=0, and stay in SEND with no bubble cycle.
REQ-022 On the last-word handshake with !hvalid and a beat accepted in the same cycle: load sreg directly from s_axis_tdata, cnt<=0, and stay in SEND.
REQ-023 On the last-word handshake with neither source available: go to IDLE.
REQ-024 Sustained throughput SHALL be one PS word per cycle while m_axis_tready stays high; input is stalled only through s_axis_tready.
REQ-025 m_axis_tready low SHALL freeze sreg, cnt, and the FSM; hbuf still accepts one beat.
REQ-026 No data SHALL be dropped or duplicated under any combination of stalls.

Reset
REQ-027 While rst is low: FSM=IDLE, cnt=0, sreg=0, hbuf=0, hvalid=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=1.
REQ-028 Reset asserted mid-beat SHALL discard the partial beat and the held beat; after release, the first word out is the MSB word of the next accepted beat.

Structure
REQ-029 words_per_beat and the FSM state enum SHALL be declared in the shared package rfsoc_config, together with the 256-bit PL bus width constant.
REQ-030 No sub-module is required; hbuf is a one-entry skid stage inside the block; any deeper buffering uses axis_sync_fifo instantiated by the integrator.

Verification
REQ-031 Single beat 0x00000007_00000006_..._00000000, m_axis_tready=1 -> words 7,6,5,4,3,2,1,0 on consecutive cycles starting 1 cycle after acceptance; tlast only on word 0.
REQ-032 Three back-to-back beats, s_axis_tvalid and m_axis_tready held high -> 24 contiguous words with tlast every 8th and no gap; s_axis_tready low while hbuf is full.
REQ-033 Random m_axis_tready (50%) with 100 random beats -> output stream equals the per-beat MSB-first concatenation; data stable during stalls.
REQ-034 m_axis_tready=0 for 20 cycles after the first beat, two more beats offered -> second beat held in hbuf, s_axis_tready=0, third beat not accepted until the last word of the first beat is accepted.
REQ-035 rst pulsed low after 3 words of a beat, with hbuf full -> all outputs at reset values, s_axis_tready=1; the next beat 0xAAAA..._0001 emits 0xAAAAAAAA first.
REQ-036 ps_axis_width=64 build, beat 0x3..._2..._1..._0 -> four 64-bit words 3,2,1,0; tlast on the fourth word.
